tm_spike_synapse: RTL and testbench
===================================

Name: tm_spike_synapse

Overview:
Time-multiplexed synaptic integrator: the spike-to-current end of the neuron interface. It takes a spike vector from a neuron layer and walks its inputs one per cycle, summing a signed per-input weight for each set spike. It folds the sum into a decaying synaptic trace and presents the trace as an 8-bit unsigned current with a valid/ready handshake. The output feeds the current input of the time-multiplexed LIF neuron stage.

Parameters:
N_IN, 8, number of spike inputs / weights (power of two, >=2)
W_W, 8, weight width, signed two's complement
CUR_W, 8, output current / trace width, unsigned
ACC_W, 12, signed accumulator width; must hold N_IN*min(weight) without overflow
DECAY_SHIFT, 1, trace decay: trace_next = (trace >> DECAY_SHIFT) + sum
IDX_W, $clog2(N_IN), index / weight-address width

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
spike_in  in  N_IN  spike vector; bit i = input i fired
spike_valid  in  1  spike_in valid
spike_ready  out  1  block can accept a spike vector
w_we  in  1  weight write enable
w_addr  in  IDX_W  weight index
w_data  in  W_W  signed weight value
cur_out  out  CUR_W  current to neuron
cur_valid  out  1  cur_out valid
cur_ready  in  1  downstream accepts cur_out

Behaviour:
- Reset (clk edge with rst_n=0) overrides everything and may occur in any state, including mid-ACCUM or OUT:
  - state=IDLE, idx=0, acc=0, trace=0, snapshot=0, all weights=0.
  - Outputs: spike_ready=1 (after reset), cur_valid=0, cur_out=0.
  - Any in-flight vector is dropped.
- FSM IDLE:
  - spike_ready=1, cur_valid=0.
  - On spike_valid & spike_ready: latch spike_in into snapshot, acc<=0, idx<=0, go to ACCUM.
- FSM ACCUM (exactly N_IN cycles):
  - spike_ready=0, cur_valid=0.
  - Each cycle: acc <= acc + (snapshot[idx] ? sext(weight[idx]) : 0); idx <= idx+1.
  - In the cycle with idx==N_IN-1, the final term is added combinationally and the trace is updated:
    - t = (trace >> DECAY_SHIFT) + acc + term, computed signed at ACC_W+1 bits.
    - trace <= clamp(t, 0, 2^CUR_W-1).
    - Go to OUT; idx wraps to 0.
- FSM OUT:
  - cur_valid=1; cur_out=trace, held stable while cur_ready=0.
  - spike_ready=0; spike_valid is ignored.
  - On cur_ready: go to IDLE.
  - No same-cycle accept of a new vector on the output handshake; minimum spacing between accepts is N_IN+2 cycles.
- Latency: vector accepted at edge of cycle 0; ACCUM in cycles 1..N_IN; cur_valid first high in cycle N_IN+1 (cycle 9 for N_IN=8).
- cur_out equals trace in all states (registered); cur_valid gates its meaning.
- Weight writes:
  - Accepted in any state; take effect at the clock edge.
  - A write to the index being read in the same ACCUM cycle: read uses the old value (read-before-write).
- All-zero spike vector: still runs the full N_IN cycles; sum=0, so the trace decays only.
- Saturation:
  - The accumulator never overflows given ACC_W.
  - Clamping occurs only at the trace update: negative sums floor at 0, large sums cap at 255.

Decomposition:
- Shared package: FSM state enum (IDLE, ACCUM, OUT); N_IN/W_W/CUR_W defaults; a saturating clamp function (signed wide -> unsigned CUR_W). The clamp is reused by other neuron-stage blocks.
- One natural sub-module: tm_weight_rf. N_IN x W_W register file, one synchronous write port, one combinational read port indexed by idx, reset to 0.

Test Plan:
- Basic sum: w[0]=10, w[3]=20, spikes 8'b0000_1001, trace 0 -> cur_valid in cycle 9, cur_out=30.
- Decay: repeat the same vector -> 15+30 = 45. Then send an all-zero vector -> 22.
- Clamp: all w=127, spikes 8'hFF -> 1016 clamps to cur_out=255. Then all w=-128, spikes 8'hFF -> 127-1024 clamps to 0.
- Back-pressure: hold cur_ready=0 for 5 cycles after cur_valid -> cur_out stable, spike_ready=0, spike_valid pulses ignored. Then cur_ready=1 -> IDLE next cycle, spike_ready=1.
- Weight write hazard: during ACCUM at idx=2, write w[2]=50 (old value 5), spike bit 2 set -> this pass uses 5. The next pass uses 50.
- Reset mid-ACCUM: assert rst_n=0 at idx=4 -> next cycle spike_ready=1, cur_valid=0, cur_out=0. All weights read 0, so a subsequent 8'hFF vector yields 0.

Source files
------------

// File: rtl/tm_spike_synapse_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tm_spike_synapse_pkg
//  Description : Shared types, defaults and the saturating clamp used by the
//                time-multiplexed neuron-stage blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package tm_spike_synapse_pkg;

    // Default geometry of the synaptic integrator
    localparam int C_N_IN        = 8;
    localparam int C_W_W         = 8;
    localparam int C_CUR_W       = 8;
    localparam int C_ACC_W       = 12;
    localparam int C_DECAY_SHIFT = 1;

    // FSM state encoding
    localparam int         C_STATE_W = 2;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCUM  = 2'd1;
    localparam logic [1:0] ST_OUT    = 2'd2;

    // Saturate a signed value into the unsigned range [0, 2^cur_w-1].
    // Callers narrow the 32-bit result to their own current width.
    function automatic logic [31:0] sat_clamp(input logic signed [31:0] value,
                                              input int unsigned        cur_w);
        logic [31:0] max_v;
        max_v = (32'd1 << cur_w) - 32'd1;
        if (value < 0)
            return 32'd0;
        else if ($unsigned(value) > max_v)
            return max_v;
        else
            return $unsigned(value);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tm_spike_synapse_weight_rf.sv
`default_nettype none
// ============================================================================
//  Module      : tm_weight_rf
//  Description : N_IN x W_W weight register file. One synchronous write port,
//                one combinational read port; contents clear on reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tm_weight_rf
    import tm_spike_synapse_pkg::*;
#(
    parameter int N_IN  = C_N_IN,
    parameter int W_W   = C_W_W,
    parameter int IDX_W = $clog2(N_IN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [W_W-1:0]   i_wdata,
    input  logic [IDX_W-1:0] i_raddr,
    output logic [W_W-1:0]   o_rdata
);

    logic [W_W-1:0] r_mem [N_IN];

    // Weight storage: reset clears every entry, otherwise write the addressed one
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_IN; i++) begin
            if (!rst_n)
                r_mem[i] <= '0;
            else if (i_we && (i_waddr == IDX_W'(i)))
                r_mem[i] <= i_wdata;
        end
    end

    // Read sees the stored value, so a same-cycle write is observed next cycle
    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/tm_spike_synapse.sv
`default_nettype none
// ============================================================================
//  Module      : tm_spike_synapse
//  Description : Time-multiplexed synaptic integrator. Walks a latched spike
//                vector one input per cycle, sums the weights of set spikes,
//                folds the sum into a decaying trace and presents the clamped
//                trace as a current with a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tm_spike_synapse
    import tm_spike_synapse_pkg::*;
#(
    parameter int N_IN        = C_N_IN,
    parameter int W_W         = C_W_W,
    parameter int CUR_W       = C_CUR_W,
    parameter int ACC_W       = C_ACC_W,
    parameter int DECAY_SHIFT = C_DECAY_SHIFT,
    parameter int IDX_W       = $clog2(N_IN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IN-1:0]  spike_in,
    input  logic             spike_valid,
    output logic             spike_ready,
    input  logic             w_we,
    input  logic [IDX_W-1:0] w_addr,
    input  logic [W_W-1:0]   w_data,
    output logic [CUR_W-1:0] cur_out,
    output logic             cur_valid,
    input  logic             cur_ready
);

    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(N_IN - 1);

    logic [C_STATE_W-1:0] r_state;
    logic [C_STATE_W-1:0] w_state_next;
    logic [IDX_W-1:0]     r_idx;
    logic [N_IN-1:0]      r_snap;
    logic signed [ACC_W-1:0] r_acc;
    logic [CUR_W-1:0]     r_trace;

    logic [W_W-1:0]          w_weight;
    logic signed [ACC_W-1:0] w_term;
    logic signed [ACC_W:0]   w_trace_dec;
    logic signed [ACC_W:0]   w_t;
    logic signed [31:0]      w_t32;
    logic                    w_last;

    tm_weight_rf #(
        .N_IN  (N_IN),
        .W_W   (W_W),
        .IDX_W (IDX_W)
    ) u_weight_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_we),
        .i_waddr (w_addr),
        .i_wdata (w_data),
        .i_raddr (r_idx),
        .o_rdata (w_weight)
    );

    assign w_last = (r_idx == C_LAST_IDX);

    // Current term: sign-extended weight when this input spiked, else zero
    assign w_term = r_snap[r_idx] ? {{(ACC_W - W_W){w_weight[W_W-1]}}, w_weight}
                                  : '0;

    // Decayed trace plus full sum, one bit wider than the accumulator so the
    // positive trace and a most-negative sum can both be represented
    assign w_trace_dec = {{(ACC_W + 1 - CUR_W){1'b0}}, (r_trace >> DECAY_SHIFT)};
    assign w_t         = w_trace_dec + {r_acc[ACC_W-1], r_acc} + {w_term[ACC_W-1], w_term};
    assign w_t32       = {{(32 - ACC_W - 1){w_t[ACC_W]}}, w_t};

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    // Next-state logic: accept in IDLE, walk N_IN inputs, hold result until taken
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (spike_valid) w_state_next = ST_ACCUM;
            ST_ACCUM: if (w_last)      w_state_next = ST_OUT;
            ST_OUT:   if (cur_ready)   w_state_next = ST_IDLE;
            default:                   w_state_next = ST_IDLE;
        endcase
    end

    // Datapath: snapshot on accept, accumulate per input, update trace on the last
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_snap  <= '0;
            r_acc   <= '0;
            r_trace <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (spike_valid) begin
                        r_snap <= spike_in;
                        r_acc  <= '0;
                        r_idx  <= '0;
                    end
                end
                ST_ACCUM: begin
                    r_acc <= r_acc + w_term;
                    r_idx <= r_idx + 1'b1;
                    if (w_last)
                        r_trace <= CUR_W'(sat_clamp(w_t32, CUR_W));
                end
                default: ;
            endcase
        end
    end

    assign spike_ready = (r_state == ST_IDLE);
    assign cur_valid   = (r_state == ST_OUT);
    assign cur_out     = r_trace;

endmodule
`default_nettype wire

// File: tb/tb_tm_spike_synapse.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tm_spike_synapse
//  Description : Self-checking bench for tm_spike_synapse: table of directed
//                vectors, hand-written handshake/hazard/reset sequences and a
//                randomized run against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tm_spike_synapse;

    localparam int N_IN = 8;
    localparam int DS   = 1;

    logic       clk;
    logic       rst_n;
    logic [7:0] spike_in;
    logic       spike_valid;
    logic       spike_ready;
    logic       w_we;
    logic [2:0] w_addr;
    logic [7:0] w_data;
    logic [7:0] cur_out;
    logic       cur_valid;
    logic       cur_ready;

    int errors;
    int checks;

    // Reference state: weights as signed integers and the current trace
    int wm [N_IN];
    int trace_m;

    typedef struct {
        logic [7:0] spikes;
        bit         fill_w;
        int         fill_val;
        int         exp_out;
    } vec_t;

    vec_t tbl [5];

    tm_spike_synapse dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spike_in    (spike_in),
        .spike_valid (spike_valid),
        .spike_ready (spike_ready),
        .w_we        (w_we),
        .w_addr      (w_addr),
        .w_data      (w_data),
        .cur_out     (cur_out),
        .cur_valid   (cur_valid),
        .cur_ready   (cur_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: integrate one vector into the trace with plain integer maths
    function automatic int model_step(input logic [7:0] sp);
        int sum;
        int t;
        sum = 0;
        for (int i = 0; i < N_IN; i++)
            if (sp[i]) sum += wm[i];
        t = (trace_m / (1 << DS)) + sum;
        if (t < 0)   t = 0;
        if (t > 255) t = 255;
        trace_m = t;
        return t;
    endfunction

    task automatic write_w(input int a, input int v);
        w_we   = 1'b1;
        w_addr = 3'(a);
        w_data = 8'(v);
        @(posedge clk); #1;
        w_we   = 1'b0;
        wm[a]  = int'($signed(8'(v)));
    endtask

    // Send one vector, optionally write a weight mid-pass (at accumulation
    // step wr_at), hold cur_ready low for 'hold' cycles, then release.
    task automatic run_vec(input logic [7:0] sp, input int hold, input int wr_at,
                           input int wa, input int wd, input int exp);
        int guard;
        int n;
        guard = 0;
        while (!spike_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        spike_in    = sp;
        spike_valid = 1'b1;
        cur_ready   = 1'b0;
        @(posedge clk); #1;
        spike_valid = 1'b0;
        n = 0;
        while (!cur_valid && n < 40) begin
            if (n == wr_at) begin
                w_we   = 1'b1;
                w_addr = 3'(wa);
                w_data = 8'(wd);
            end
            @(posedge clk); #1;
            w_we = 1'b0;
            n++;
        end
        if (wr_at >= 0) wm[wa] = int'($signed(8'(wd)));
        chk("latency", n, N_IN);
        chk("cur_out", int'(cur_out), exp);
        for (int h = 0; h < hold; h++) begin
            spike_valid = h[0];
            spike_in    = 8'hFF;
            @(posedge clk); #1;
            chk("hold_valid", int'(cur_valid), 1);
            chk("hold_cur_out", int'(cur_out), exp);
            chk("hold_spike_ready", int'(spike_ready), 0);
        end
        spike_valid = 1'b0;
        cur_ready   = 1'b1;
        @(posedge clk); #1;
        cur_ready   = 1'b0;
        chk("idle_spike_ready", int'(spike_ready), 1);
        chk("idle_cur_valid", int'(cur_valid), 0);
    endtask

    initial begin
        int exp;
        logic [7:0] sp;
        errors      = 0;
        checks      = 0;
        trace_m     = 0;
        for (int i = 0; i < N_IN; i++) wm[i] = 0;
        rst_n       = 1'b0;
        spike_in    = '0;
        spike_valid = 1'b0;
        w_we        = 1'b0;
        w_addr      = '0;
        w_data      = '0;
        cur_ready   = 1'b0;

        tbl[0] = '{8'h09, 1'b0, 0,    30};
        tbl[1] = '{8'h09, 1'b0, 0,    45};
        tbl[2] = '{8'h00, 1'b0, 0,    22};
        tbl[3] = '{8'hFF, 1'b1, 127,  255};
        tbl[4] = '{8'hFF, 1'b1, -128, 0};

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_spike_ready", int'(spike_ready), 1);
        chk("rst_cur_valid", int'(cur_valid), 0);
        chk("rst_cur_out", int'(cur_out), 0);

        // Directed table: basic sum, decay, zero vector, both clamp limits
        write_w(0, 10);
        write_w(3, 20);
        for (int k = 0; k < 5; k++) begin
            if (tbl[k].fill_w)
                for (int i = 0; i < N_IN; i++) write_w(i, tbl[k].fill_val);
            void'(model_step(tbl[k].spikes));
            run_vec(tbl[k].spikes, 0, -1, 0, 0, tbl[k].exp_out);
        end

        // Back-pressure: result held 5 cycles with spike_valid pulses ignored
        write_w(1, 7);
        void'(model_step(8'h02));
        run_vec(8'h02, 5, -1, 0, 0, 7);

        // Write hazard at idx 2: this pass uses the old weight 5, next uses 50
        write_w(2, 5);
        void'(model_step(8'h04));
        run_vec(8'h04, 0, 2, 2, 50, 8);
        void'(model_step(8'h04));
        run_vec(8'h04, 0, -1, 0, 0, 54);

        // Randomized vectors, weights and back-pressure against the model
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 1) == 1)
                write_w(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
            sp  = 8'($urandom);
            exp = model_step(sp);
            run_vec(sp, int'($urandom_range(0, 3)), -1, 0, 0, exp);
        end

        // Reset in the middle of accumulation
        spike_in    = 8'hFF;
        spike_valid = 1'b1;
        @(posedge clk); #1;
        spike_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_spike_ready", int'(spike_ready), 1);
        chk("midrst_cur_valid", int'(cur_valid), 0);
        chk("midrst_cur_out", int'(cur_out), 0);
        for (int i = 0; i < N_IN; i++) wm[i] = 0;
        trace_m = 0;
        void'(model_step(8'hFF));
        run_vec(8'hFF, 0, -1, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
